mul12_rr_arbiter: RTL and testbench
===================================

# mul12_rr_arbiter

Shares one 12x12 Karatsuba multiplier datapath among N_REQ requesters through round-robin arbitration. Accepts at most one operand pair per cycle and pushes it through a fixed-latency pipeline. Returns the 24-bit product tagged with the originating requester index. Sits between the NTT butterfly/twiddle lanes and the single shared multiplier instance.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- PIPE_STAGES, 2: product register stages after the operand register, >=1. Retiming across them is allowed.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- enable_i  input  1  when low, no new acceptance; in-flight operations drain.
- req_valid_i  input  N_REQ  per-requester operand valid.
- req_a_i  input  12*N_REQ  operand A; requester r uses bits [12r+11:12r].
- req_b_i  input  12*N_REQ  operand B, same packing.
- req_ready_o  output  N_REQ  one-hot grant; zero or one bit set.
- rsp_valid_o  output  N_REQ  one-hot response pulse to the owning requester.
- rsp_p_o  output  24  product a*b, unsigned.
- rsp_id_o  output  clog2(N_REQ)  requester index of the current response.
- busy_o  output  1  high while any pipeline stage holds a valid entry.

## Operation
- Arbitration is combinational. Grant goes to the first requester r with req_valid_i[r]=1, searching from (last_grant+1) mod N_REQ upward with wrap-around.
- req_ready_o[r]=1 only for the granted r, and only when enable_i=1. It may depend combinationally on req_valid_i.
- Handshake: transfer occurs when req_valid_i[r] & req_ready_o[r] is high at a rising edge.
- A requester holds valid and operands stable until it is accepted.
- last_grant updates to r only on a transfer. With no transfer, the pointer holds.
- Operand stage: on transfer, a, b, id and valid=1 are registered. Otherwise valid=0 is registered; data is don't-care.
- Datapath: unsigned multiply on the operand-stage outputs, split as high/low 6-bit halves Karatsuba-style: z2*2^12 + z1*2^6 + z0.
  - The middle term z1 = (ah+al)(bh+bl) - z0 - z2 uses a 7-bit sum and a 14-bit intermediate.
  - The result is exact over the full 0..4095 range, with no truncation.
- Product pipeline: PIPE_STAGES registers carry {valid, id, product}. Each entry advances every cycle. There is no stall and no backpressure on responses.
- Outputs are taken from the final stage:
  - rsp_valid_o = valid ? (1<<id) : 0.
  - rsp_p_o and rsp_id_o are held at the last value when valid=0; verification must not check them then.
- busy_o = OR of all stage valid bits, operand stage included.
- enable_i low mid-stream: acceptance stops that cycle; already-accepted entries still complete; last_grant holds.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all stage valids = 0; rsp_valid_o = 0; busy_o = 0; rsp_p_o = 0; rsp_id_o = 0.
  - last_grant = N_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards every in-flight entry; no response is produced for them.
- Latency: a transfer at edge E yields its response in the cycle following edge E+PIPE_STAGES. This is PIPE_STAGES+1 cycles after the accept cycle; default is 3.
- Throughput: one transfer per cycle sustained. Responses leave in acceptance order, one per cycle at most.
- Fairness: with all N_REQ requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,...; each requester waits at most N_REQ-1 cycles.
- Simultaneous events: a new transfer and a response for the same requester in the same cycle are independent and both occur.
- req_ready_o is low for all requesters while rst_i is high.

## Test plan
- Single requester, PIPE_STAGES=2:
  - r2 sends a=123, b=456 at edge E -> rsp_valid_o=4'b0100, rsp_id_o=2, rsp_p_o=56088 in the cycle after E+2.
  - busy_o high for exactly 3 cycles.
- Corners:
  - 4095*4095 -> 16769025 (0xFFE001); 0*4095 -> 0; 2048*2048 -> 4194304.
  - 63*64 -> 4032 (exercises the 6-bit split carry).
  - Each case issued back-to-back from one requester; responses in order, one per cycle.
- All four requesters valid continuously for 12 cycles after reset:
  - grants exactly 0,1,2,3 three times;
  - each response id matches its grant, and each product matches its operands.
- Sparse requests with pointer wrap:
  - last_grant=3; r1 and r3 valid -> r1 granted, then r3.
  - Next: r0 and r3 valid with last_grant=3 -> r0.
- enable_i dropped for 4 cycles with two entries in flight:
  - no req_ready_o; both responses still emitted; busy_o falls afterwards.
  - Grants resume from the held pointer.
- rst_i asserted asynchronously (mid-cycle) with three entries in flight:
  - rsp_valid_o and busy_o go to 0 immediately; no stale responses after release.
  - The first grant after release goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mul12_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mul12_rr_arbiter
// Round-robin front end sharing one 12x12 Karatsuba multiplier pipeline.
// Rev 1.0
// ============================================================================

module mul12_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [12*N_REQ-1:0]      req_a_i,
  input  logic [12*N_REQ-1:0]      req_b_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         rsp_valid_o,
  output logic [23:0]              rsp_p_o,
  output logic [$clog2(N_REQ)-1:0] rsp_id_o,
  output logic                     busy_o
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             xfer;
  logic [11:0]      sel_a, sel_b;
  int               cand;

  logic             op_valid_q, op_valid_d;
  logic [11:0]      op_a_q, op_a_d;
  logic [11:0]      op_b_q, op_b_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;

  logic [5:0]       a_hi, a_lo, b_hi, b_lo;
  logic [11:0]      z0, z2;
  logic [6:0]       a_sum, b_sum;
  logic [13:0]      mid, z1;
  logic [23:0]      prod;

  logic [PIPE_STAGES-1:0] pv_q, pv_d;
  logic [ID_W-1:0]        pid_q [PIPE_STAGES];
  logic [ID_W-1:0]        pid_d [PIPE_STAGES];
  logic [23:0]            pp_q  [PIPE_STAGES];
  logic [23:0]            pp_d  [PIPE_STAGES];

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(last_grant_q) + i) % N_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found && enable_i && !rst_i) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign req_ready_o = grant_oh;
  assign xfer        = |(req_valid_i & grant_oh);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_idx == r[ID_W-1:0]) begin
        sel_a = req_a_i[12*r +: 12];
        sel_b = req_b_i[12*r +: 12];
      end
    end
  end

  always_comb begin
    last_grant_d = xfer ? grant_idx : last_grant_q;
    op_valid_d   = xfer;
    op_a_d       = xfer ? sel_a : op_a_q;
    op_b_d       = xfer ? sel_b : op_b_q;
    op_id_d      = xfer ? grant_idx : op_id_q;
  end

  // Karatsuba on 6-bit halves; the 14-bit middle product is exact, and
  // subtracting z0+z2 modulo 2^14 still leaves the true (non-negative) z1.
  always_comb begin
    a_hi  = op_a_q[11:6];
    a_lo  = op_a_q[5:0];
    b_hi  = op_b_q[11:6];
    b_lo  = op_b_q[5:0];
    z0    = {6'b0, a_lo} * {6'b0, b_lo};
    z2    = {6'b0, a_hi} * {6'b0, b_hi};
    a_sum = {1'b0, a_hi} + {1'b0, a_lo};
    b_sum = {1'b0, b_hi} + {1'b0, b_lo};
    mid   = {7'b0, a_sum} * {7'b0, b_sum};
    z1    = mid - {2'b0, z0} - {2'b0, z2};
    prod  = {z2, 12'b0} + {4'b0, z1, 6'b0} + {12'b0, z0};
  end

  // Payload only moves with a valid entry so the output holds its last value.
  always_comb begin
    pv_d[0]  = op_valid_q;
    pid_d[0] = op_valid_q ? op_id_q : pid_q[0];
    pp_d[0]  = op_valid_q ? prod    : pp_q[0];
    for (int s = 1; s < PIPE_STAGES; s++) begin
      pv_d[s]  = pv_q[s-1];
      pid_d[s] = pv_q[s-1] ? pid_q[s-1] : pid_q[s];
      pp_d[s]  = pv_q[s-1] ? pp_q[s-1]  : pp_q[s];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      pv_q         <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pid_q[s] <= '0;
        pp_q[s]  <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      pv_q         <= pv_d;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pid_q[s] <= pid_d[s];
        pp_q[s]  <= pp_d[s];
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (pv_q[PIPE_STAGES-1]) begin
      rsp_valid_o[pid_q[PIPE_STAGES-1]] = 1'b1;
    end
  end

  assign rsp_p_o  = pp_q[PIPE_STAGES-1];
  assign rsp_id_o = pid_q[PIPE_STAGES-1];
  assign busy_o   = op_valid_q | (|pv_q);

endmodule

`default_nettype wire

// File: tb/tb_mul12_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mul12_rr_arbiter
// Directed and randomized stimulus against a queue-based reference model.
// Rev 1.0
// ============================================================================

module tb_mul12_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int PS    = 2;
  localparam int ID_W  = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  enable_i;
  logic [N_REQ-1:0]      req_valid_i;
  logic [12*N_REQ-1:0]   req_a_i;
  logic [12*N_REQ-1:0]   req_b_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ-1:0]      rsp_valid_o;
  logic [23:0]           rsp_p_o;
  logic [ID_W-1:0]       rsp_id_o;
  logic                  busy_o;

  mul12_rr_arbiter #(.N_REQ(N_REQ), .PIPE_STAGES(PS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_p_o(rsp_p_o), .rsp_id_o(rsp_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; int id; int p; } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;
  int   m_ptr  = N_REQ - 1;
  exp_t exp_q[$];
  int   seen_id[$];
  int   seen_p[$];
  logic [N_REQ-1:0] acc_mask = '0;

  bit          pend [N_REQ];
  logic [11:0] pa   [N_REQ];
  logic [11:0] pb   [N_REQ];

  task automatic chk_eq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: in-flight products kept as {due cycle, id, a*b}.
  exp_t             m_e;
  bit               m_had;
  int               m_g;
  logic [N_REQ-1:0] m_er;

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk_eq("rst_ready", req_ready_o, 0);
      chk_eq("rst_rsp_valid", rsp_valid_o, 0);
      chk_eq("rst_busy", busy_o, 0);
      chk_eq("rst_rsp_p", rsp_p_o, 0);
      chk_eq("rst_rsp_id", rsp_id_o, 0);
      exp_q.delete();
      m_ptr    = N_REQ - 1;
      acc_mask = '0;
    end else begin
      if (rsp_valid_o != '0) begin
        seen_id.push_back(int'(rsp_id_o));
        seen_p.push_back(int'(rsp_p_o));
      end
      m_had = (exp_q.size() > 0);
      chk_eq("busy", busy_o, m_had);
      if (m_had && exp_q[0].due == ncyc) begin
        m_e = exp_q.pop_front();
        chk_eq("rsp_valid", rsp_valid_o, 1 << m_e.id);
        chk_eq("rsp_id", rsp_id_o, m_e.id);
        chk_eq("rsp_p", rsp_p_o, m_e.p);
      end else begin
        chk_eq("rsp_valid_idle", rsp_valid_o, 0);
      end
      m_g = -1;
      if (enable_i) begin
        for (int i = 1; i <= N_REQ; i++) begin
          int r;
          r = (m_ptr + i) % N_REQ;
          if (m_g < 0 && req_valid_i[r]) m_g = r;
        end
      end
      m_er = (m_g >= 0) ? N_REQ'(1 << m_g) : '0;
      chk_eq("req_ready", req_ready_o, m_er);
      if (m_g >= 0) begin
        m_e.due = ncyc + PS + 1;
        m_e.id  = m_g;
        m_e.p   = int'(req_a_i[12*m_g +: 12]) * int'(req_b_i[12*m_g +: 12]);
        exp_q.push_back(m_e);
        m_ptr = m_g;
      end
      acc_mask = m_er;
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int r = 0; r < N_REQ; r++) if (acc_mask[r]) pend[r] = 1'b0;
  endtask

  task automatic post(input int r, input int a, input int b);
    pend[r] = 1'b1;
    pa[r]   = a[11:0];
    pb[r]   = b[11:0];
  endtask

  task automatic apply();
    for (int r = 0; r < N_REQ; r++) begin
      req_valid_i[r]        = pend[r];
      req_a_i[12*r +: 12]   = pa[r];
      req_b_i[12*r +: 12]   = pb[r];
    end
    #1;
  endtask

  function automatic bit any_pend();
    bit x = 1'b0;
    for (int r = 0; r < N_REQ; r++) x |= pend[r];
    return x;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((any_pend() || busy_o) && n < 60) begin
      tick();
      apply();
      n++;
    end
    chk_eq("idle_timeout", n < 60, 1);
  endtask

  function automatic int rnd_op();
    case ($urandom_range(0, 9))
      0: return 4095;
      1: return 0;
      2: return 63;
      3: return 64;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int busy_cnt;
  int posted [N_REQ];
  int ca [4] = '{4095, 0, 2048, 63};
  int cb [4] = '{4095, 4095, 2048, 64};
  int cp [4] = '{16769025, 0, 4194304, 4032};

  initial begin
    rst_i       = 1'b1;
    enable_i    = 1'b1;
    req_valid_i = '1;
    req_a_i     = '0;
    req_b_i     = '0;
    for (int r = 0; r < N_REQ; r++) begin
      pend[r] = 1'b0; pa[r] = '0; pb[r] = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk_eq("reset_ready", req_ready_o, 0);
    chk_eq("reset_rsp_valid", rsp_valid_o, 0);
    chk_eq("reset_busy", busy_o, 0);
    chk_eq("reset_rsp_p", rsp_p_o, 0);
    chk_eq("reset_rsp_id", rsp_id_o, 0);
    tick();
    rst_i = 1'b0;
    apply();

    // Single request from r2: product three cycles later, busy for three cycles.
    tick();
    post(2, 123, 456);
    apply();
    chk_eq("single_grant", req_ready_o, 4'b0100);
    busy_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      apply();
      busy_cnt += int'(busy_o);
      if (j == 2) begin
        chk_eq("single_rsp_valid", rsp_valid_o, 4'b0100);
        chk_eq("single_rsp_id", rsp_id_o, 2);
        chk_eq("single_rsp_p", rsp_p_o, 56088);
      end
    end
    chk_eq("single_busy_cycles", busy_cnt, 3);

    // Corner operands back-to-back from one requester.
    seen_id.delete();
    seen_p.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      post(0, ca[k], cb[k]);
      apply();
    end
    wait_idle();
    chk_eq("corner_count", seen_p.size(), 4);
    for (int k = 0; k < 4 && k < seen_p.size(); k++) begin
      chk_eq("corner_p", seen_p[k], cp[k]);
      chk_eq("corner_id", seen_id[k], 0);
    end

    // Fairness after reset: all four continuously valid for 12 cycles.
    tick();
    rst_i = 1'b1;
    apply();
    tick();
    rst_i = 1'b0;
    seen_id.delete();
    seen_p.delete();
    for (int r = 0; r < N_REQ; r++) posted[r] = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      for (int r = 0; r < N_REQ; r++) begin
        if (!pend[r] && posted[r] < 3) begin
          post(r, rnd_op(), rnd_op());
          posted[r]++;
        end
      end
      apply();
      chk_eq("fair_grant", req_ready_o, 1 << (k % 4));
    end
    wait_idle();
    chk_eq("fair_count", seen_id.size(), 12);
    for (int k = 0; k < 12 && k < seen_id.size(); k++) chk_eq("fair_rsp_id", seen_id[k], k % 4);

    // Sparse requests with wrap; pointer is at 3 here.
    tick();
    post(1, 100, 200);
    post(3, 300, 400);
    apply();
    chk_eq("sparse_r1", req_ready_o, 4'b0010);
    tick();
    apply();
    chk_eq("sparse_r3", req_ready_o, 4'b1000);
    tick();
    post(0, 5, 7);
    post(3, 11, 13);
    apply();
    chk_eq("sparse_wrap_r0", req_ready_o, 4'b0001);
    wait_idle();

    // Enable dropped for four cycles with two entries in flight.
    tick();
    post(0, 1000, 3);
    post(1, 77, 4095);
    apply();
    tick();
    apply();
    tick();
    enable_i = 1'b0;
    post(2, 9, 9);
    post(0, 17, 19);
    for (int m = 0; m < 4; m++) begin
      if (m > 0) tick();
      apply();
      chk_eq("disabled_ready", req_ready_o, 0);
      if (m == 3) chk_eq("disabled_busy_drained", busy_o, 0);
    end
    tick();
    enable_i = 1'b1;
    apply();
    chk_eq("resume_grant", req_ready_o, 4'b0100);
    wait_idle();

    // Asynchronous reset with three entries in flight.
    tick();
    post(0, 4095, 1);
    post(1, 2, 4095);
    post(2, 321, 654);
    apply();
    tick();
    apply();
    tick();
    apply();
    tick();
    post(3, 12, 34);
    post(1, 56, 78);
    apply();
    #1;
    rst_i = 1'b1;
    #1;
    chk_eq("async_rst_rsp_valid", rsp_valid_o, 0);
    chk_eq("async_rst_busy", busy_o, 0);
    chk_eq("async_rst_ready", req_ready_o, 0);
    tick();
    rst_i = 1'b0;
    apply();
    chk_eq("post_rst_grant", req_ready_o, 4'b0010);
    wait_idle();

    // Randomized traffic with occasional enable drops.
    for (int c = 0; c < 800; c++) begin
      tick();
      enable_i = ($urandom_range(0, 9) != 0);
      for (int r = 0; r < N_REQ; r++) begin
        if (!pend[r] && $urandom_range(0, 99) < 35) post(r, rnd_op(), rnd_op());
      end
      apply();
    end
    enable_i = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
